// File: rtl/halut_pkg.sv
// Shared types and helpers for the HALUT decision-tree encoder.
package halut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Index of the first node of a tree level in breadth-first order.
    function automatic int unsigned node_offset(input int unsigned level);
        return (32'd1 << level) - 32'd1;
    endfunction

    function automatic int unsigned min_width(input int unsigned w);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

    // IEEE half-precision a > b; NaN operands and +0 vs -0 never compare greater.
    function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
        logic a_nan;
        logic b_nan;
        logic both_zero;
        logic res;
        a_nan     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
        if (a_nan || b_nan || both_zero) begin
            res = 1'b0;
        end else if (a[15] != b[15]) begin
            res = ~a[15];
        end else if (!a[15]) begin
            res = (a[14:0] > b[14:0]);
        end else begin
            res = (a[14:0] < b[14:0]);
        end
        return res;
    endfunction

endpackage

// File: rtl/halut_thresh_mem.sv
// Threshold storage: registered write, combinational read, cleared on reset.
module halut_thresh_mem #(
    parameter int unsigned Depth     = 128,
    parameter int unsigned Width     = 16,
    parameter int unsigned AddrWidth = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    // Next memory contents
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end else begin
            mem_d[waddr_i] = mem_q[waddr_i];
        end
    end

    // Storage flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/halut_encoder_tree.sv
// HALUT encoder unit: one balanced-tree level per cycle, valid/ready on both sides.
module halut_encoder_tree
    import halut_pkg::*;
#(
    parameter int unsigned K             = 16,
    parameter int unsigned C             = 32,
    parameter int unsigned EncUnits      = 4,
    parameter int unsigned DataTypeWidth = 16,
    parameter int unsigned EncUnitNumber = 0,
    localparam int unsigned TreeDepth          = $clog2(K),
    localparam int unsigned CPerEncUnit        = C / EncUnits,
    localparam int unsigned CAddrWidth         = $clog2(C),
    localparam int unsigned ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
    localparam int unsigned LvlWidth           = (TreeDepth > 1) ? $clog2(TreeDepth) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    in_valid_i,
    output logic                                    in_ready_o,
    input  logic [TreeDepth-1:0][DataTypeWidth-1:0] a_input_i,
    input  logic [ThreshMemAddrWidth-1:0]           waddr_i,
    input  logic [DataTypeWidth-1:0]               wdata_i,
    input  logic                                    we_i,
    input  logic                                    c_clear_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [CAddrWidth-1:0]                   c_addr_o,
    output logic [TreeDepth-1:0]                    k_addr_o
);

    localparam int unsigned CLocWidth = min_width($clog2(CPerEncUnit));

    state_e                                  state_q, state_d;
    logic [LvlWidth-1:0]                     level_q, level_d;
    logic [TreeDepth-1:0]                    node_q, node_d;
    logic [CLocWidth-1:0]                    c_local_q, c_local_d;
    logic                                    clr_pend_q, clr_pend_d;
    logic [TreeDepth-1:0][DataTypeWidth-1:0] operand_q, operand_d;
    logic [TreeDepth-1:0]                    k_addr_q, k_addr_d;
    logic [CAddrWidth-1:0]                   c_addr_q, c_addr_d;
    logic                                    out_valid_q, out_valid_d;
    logic                                    in_ready_q, in_ready_d;

    logic [ThreshMemAddrWidth-1:0] raddr_s;
    logic [DataTypeWidth-1:0]      thresh_s;
    logic                          bit_s;
    logic [TreeDepth-1:0]          node_next_s;
    logic                          last_lvl_s;

    halut_thresh_mem #(
        .Depth    (CPerEncUnit * K),
        .Width    (DataTypeWidth),
        .AddrWidth(ThreshMemAddrWidth)
    ) u_thresh_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (we_i),
        .waddr_i(waddr_i),
        .wdata_i(wdata_i),
        .raddr_i(raddr_s),
        .rdata_o(thresh_s)
    );

    // Threshold lookup and one-level compare
    always_comb begin
        raddr_s = ThreshMemAddrWidth'(32'(c_local_q) * K + node_offset(32'(level_q)) + 32'(node_q));
        bit_s       = fp16_gt(operand_q[level_q], thresh_s);
        node_next_s = TreeDepth'({node_q, bit_s});
        last_lvl_s  = (32'(level_q) == TreeDepth - 32'd1);
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        node_d      = node_q;
        c_local_d   = c_local_q;
        clr_pend_d  = clr_pend_q;
        operand_d   = operand_q;
        k_addr_d    = k_addr_q;
        c_addr_d    = c_addr_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (c_clear_i) begin
                    c_local_d = '0;
                end else begin
                    c_local_d = c_local_q;
                end
                if (in_valid_i) begin
                    operand_d  = a_input_i;
                    level_d    = '0;
                    node_d     = '0;
                    state_d    = ENCODE;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end
            end
            ENCODE: begin
                if (last_lvl_s) begin
                    k_addr_d    = node_next_s;
                    c_addr_d    = CAddrWidth'(EncUnitNumber + 32'(c_local_q) * EncUnits);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    level_d     = '0;
                    node_d      = '0;
                    clr_pend_d  = 1'b0;
                    // A clear seen during this row only takes effect once its result is formed.
                    if (c_clear_i || clr_pend_q) begin
                        c_local_d = '0;
                    end else if (32'(c_local_q) == CPerEncUnit - 32'd1) begin
                        c_local_d = '0;
                    end else begin
                        c_local_d = c_local_q + CLocWidth'(1);
                    end
                end else begin
                    node_d     = node_next_s;
                    level_d    = level_q + LvlWidth'(1);
                    clr_pend_d = clr_pend_q | c_clear_i;
                end
            end
            HOLD: begin
                if (c_clear_i) begin
                    c_local_d = '0;
                end else begin
                    c_local_d = c_local_q;
                end
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            level_q     <= '0;
            node_q      <= '0;
            c_local_q   <= '0;
            clr_pend_q  <= 1'b0;
            operand_q   <= '0;
            k_addr_q    <= '0;
            c_addr_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            node_q      <= node_d;
            c_local_q   <= c_local_d;
            clr_pend_q  <= clr_pend_d;
            operand_q   <= operand_d;
            k_addr_q    <= k_addr_d;
            c_addr_q    <= c_addr_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign k_addr_o    = k_addr_q;
    assign c_addr_o    = c_addr_q;

endmodule
